// File: rtl/bus_transfer_controller.sv
// Shared-bus transfer sequencer: queues src/dst commands and plays each one out
// as DRIVE / STROBE / HOLD on the register enables, latch strobes and host port.
module bus_transfer_controller #(
  parameter int BITS       = 8,
  parameter int N_REGS     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IW         = $clog2(N_REGS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [IW-1:0]     i_cmd_src,
  input  logic [IW-1:0]     i_cmd_dst,
  input  logic [BITS-1:0]   i_cmd_data,
  input  logic [BITS-1:0]   i_bus_in,
  output logic [BITS-1:0]   o_bus_out,
  output logic              o_bus_oe,
  output logic [N_REGS-1:0] o_reg_en,
  output logic [N_REGS-1:0] o_reg_set,
  output logic [BITS-1:0]   o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic              o_err
);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = PW + 1;
  localparam int CMDW = 2 * IW + BITS;
  localparam logic [IW-1:0]     HOST     = IW'(N_REGS);
  localparam logic [N_REGS-1:0] ONE_HOT0 = N_REGS'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CMDW-1:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [IW-1:0]     r_cur_src;
  logic [IW-1:0]     r_cur_dst;
  logic [BITS-1:0]   r_cur_data;
  logic              r_out_active;

  logic [BITS-1:0]   r_bus_out;
  logic              r_bus_oe;
  logic [N_REGS-1:0] r_reg_en;
  logic [N_REGS-1:0] r_reg_set;
  logic [BITS-1:0]   r_rd_data;
  logic              r_rd_valid;
  logic              r_err;

  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_illegal;
  logic              w_push;
  logic              w_pop;
  logic [N_REGS-1:0] w_reg_en;
  logic [N_REGS-1:0] w_reg_set;
  logic              w_bus_oe;
  logic [BITS-1:0]   w_bus_out;
  logic              w_capture;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == CW'(0));
  assign w_accept  = i_cmd_valid && !w_full;
  assign w_illegal = (i_cmd_src > HOST) || (i_cmd_dst > HOST) || (i_cmd_src == i_cmd_dst);
  assign w_push    = w_accept && !w_illegal;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;

  assign o_cmd_ready = !w_full;
  // r_out_active covers the HOLD cycle seen on the outputs after the FSM is back in IDLE
  assign o_busy      = (r_state != S_IDLE) || r_out_active || !w_empty;
  assign o_bus_out   = r_bus_out;
  assign o_bus_oe    = r_bus_oe;
  assign o_reg_en    = r_reg_en;
  assign o_reg_set   = r_reg_set;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_err       = r_err;

  // Command storage; stale entries need no reset since r_count gates every read
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= {i_cmd_src, i_cmd_dst, i_cmd_data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state and current-transfer register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cur_src  <= '0;
      r_cur_dst  <= '0;
      r_cur_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        {r_cur_src, r_cur_dst, r_cur_data} <= r_fifo[r_rptr];
      end
    end
  end

  // Next state and the bus controls that the output flops present one cycle later
  always_comb begin
    w_state_next = r_state;
    w_reg_en     = '0;
    w_reg_set    = '0;
    w_bus_oe     = 1'b0;
    w_bus_out    = '0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_next = S_DRIVE;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_DRIVE:  w_state_next = S_STROBE;
      S_STROBE: w_state_next = S_HOLD;
      S_HOLD:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (r_state != S_IDLE) begin
      if (r_cur_src == HOST) begin
        w_bus_oe  = 1'b1;
        w_bus_out = r_cur_data;
      end else begin
        w_reg_en = ONE_HOT0 << r_cur_src;
      end
    end else begin
      w_reg_en = '0;
    end
    if ((r_state == S_STROBE) && (r_cur_dst != HOST)) begin
      w_reg_set = ONE_HOT0 << r_cur_dst;
    end else begin
      w_reg_set = '0;
    end
    w_capture = (r_state == S_HOLD) && (r_cur_dst == HOST);
  end

  // Registered outputs; readback samples the bus during the visible STROBE cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_active <= 1'b0;
      r_bus_out    <= '0;
      r_bus_oe     <= 1'b0;
      r_reg_en     <= '0;
      r_reg_set    <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_out_active <= (r_state != S_IDLE);
      r_bus_out    <= w_bus_out;
      r_bus_oe     <= w_bus_oe;
      r_reg_en     <= w_reg_en;
      r_reg_set    <= w_reg_set;
      r_rd_valid   <= w_capture;
      r_err        <= w_accept && w_illegal;
      if (w_capture) begin
        r_rd_data <= i_bus_in;
      end
    end
  end

endmodule
